// File: rtl/multiplicador_seq_param_pkg.sv
// Shared constants for the sequential shift-add multiplier: FSM encodings,
// the default operand width and a constant log2 helper for counter sizing.
package multiplicador_seq_param_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ceiling log2, usable in constant expressions (value >= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/multiplicador_seq_param_if.sv
// Request/result bundle between the control unit (master) and the
// multiplier (slave). Operands and Signed are sampled together with St.
interface multiplicador_seq_param_if
  import multiplicador_seq_param_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic                 St;
  logic                 Signed;
  logic [WIDTH-1:0]     Multiplicando;
  logic [WIDTH-1:0]     Multiplicador;
  logic                 Done;
  logic                 Idle;
  logic [2*WIDTH-1:0]   Produto;

  modport master (
    output St, Signed, Multiplicando, Multiplicador,
    input  Done, Idle, Produto
  );

  modport slave (
    input  St, Signed, Multiplicando, Multiplicador,
    output Done, Idle, Produto
  );

endinterface

// File: rtl/mult_sign_adj.sv
// Conditional two's-complement negate. Used as |x| on operand entry
// (negate_i = signed mode and sign bit) and as the final product negate.
// Negating zero yields zero, so no -0 artefact can appear.
module mult_sign_adj #(
  parameter int W = 16
) (
  input  logic [W-1:0] value_i,
  input  logic         negate_i,
  output logic [W-1:0] value_o
);

  assign value_o = negate_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/multiplicador_seq_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or
// unsigned per operation. Works on magnitudes and applies the sign once
// at the end. With EARLY_EXIT the CALC phase stops as soon as no set
// multiplier bits remain. Done/Produto are registered out of the DONE state.
module multiplicador_seq_param
  import multiplicador_seq_param_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic Clk,
  input  logic Rst,
  multiplicador_seq_param_if.slave bus
);

  localparam int CW = clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  logic [1:0]       state_q,   state_d;
  logic [CW-1:0]    count_q,   count_d;
  logic [WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0] mreg_q,    mreg_d;
  logic [PW-1:0]    acc_q,     acc_d;
  logic [PW-1:0]    produto_q, produto_d;
  logic             neg_q,     neg_d;
  logic             done_q,    done_d;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    acc_signed;
  logic [WIDTH-1:0] mreg_shift;
  logic             last_step;

  // Operand magnitudes are taken only in signed mode with the sign bit set.
  mult_sign_adj #(.W(WIDTH)) u_abs_a (
    .value_i  (bus.Multiplicando),
    .negate_i (bus.Signed & bus.Multiplicando[WIDTH-1]),
    .value_o  (mag_a)
  );

  mult_sign_adj #(.W(WIDTH)) u_abs_b (
    .value_i  (bus.Multiplicador),
    .negate_i (bus.Signed & bus.Multiplicador[WIDTH-1]),
    .value_o  (mag_b)
  );

  // Final sign fix-up of the unsigned accumulator.
  mult_sign_adj #(.W(PW)) u_neg_p (
    .value_i  (acc_q),
    .negate_i (neg_q),
    .value_o  (acc_signed)
  );

  assign mreg_shift = mreg_q >> 1;

  // The WIDTH-th step always ends CALC; with EARLY_EXIT an exhausted
  // multiplier ends it sooner.
  assign last_step = (count_q == CW'(WIDTH - 1)) ||
                     (EARLY_EXIT && (mreg_shift == '0));

  // Next-state, datapath and output-register computation.
  always_comb begin
    // NOTE: every *_d starts from its flop value so no path leaves it unassigned (no latches).
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mreg_d    = mreg_q;
    acc_d     = acc_q;
    produto_d = produto_q;
    neg_d     = neg_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.St) begin
          mcand_d = mag_a;
          mreg_d  = mag_b;
          neg_d   = bus.Signed &
                    (bus.Multiplicando[WIDTH-1] ^ bus.Multiplicador[WIDTH-1]);
          count_d = '0;
          acc_d   = '0;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        if (mreg_q[0]) begin
          acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << count_q);
        end
        mreg_d  = mreg_shift;
        count_d = count_q + CW'(1);
        if (last_step) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        produto_d = acc_signed;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over St.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      mreg_q    <= '0;
      acc_q     <= '0;
      produto_q <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      mreg_q    <= mreg_d;
      acc_q     <= acc_d;
      produto_q <= produto_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
    end
  end

  assign bus.Done    = done_q;
  assign bus.Idle    = (state_q == ST_IDLE);
  assign bus.Produto = produto_q;

endmodule

// File: tb/tb_multiplicador_seq_param.sv
// Bench for multiplicador_seq_param: one fixed-latency and one early-exit
// instance (WIDTH=16). A behavioural model predicts, per cycle, Done, Idle
// and Produto from operand arithmetic and the latency rule; directed
// operations also pin results and latencies to hand-computed literals.
module tb_multiplicador_seq_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  st_i  = 2'b00;
  logic [1:0]  sgn_i = 2'b00;
  logic [15:0] a_i [2];
  logic [15:0] b_i [2];
  logic [1:0]  done_o;
  logic [1:0]  idle_o;
  logic [31:0] prod_o [2];

  multiplicador_seq_param_if #(.WIDTH(16)) bus0 ();
  multiplicador_seq_param_if #(.WIDTH(16)) bus1 ();

  assign bus0.St            = st_i[0];
  assign bus0.Signed        = sgn_i[0];
  assign bus0.Multiplicando = a_i[0];
  assign bus0.Multiplicador = b_i[0];
  assign bus1.St            = st_i[1];
  assign bus1.Signed        = sgn_i[1];
  assign bus1.Multiplicando = a_i[1];
  assign bus1.Multiplicador = b_i[1];

  assign done_o[0] = bus0.Done;
  assign idle_o[0] = bus0.Idle;
  assign prod_o[0] = bus0.Produto;
  assign done_o[1] = bus1.Done;
  assign idle_o[1] = bus1.Idle;
  assign prod_o[1] = bus1.Produto;

  multiplicador_seq_param #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
    .Clk (clk),
    .Rst (rst),
    .bus (bus0)
  );

  multiplicador_seq_param #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (
    .Clk (clk),
    .Rst (rst),
    .bus (bus1)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mathematical product truncated to 32 bits.
  function automatic logic [31:0] ref_product(input bit s, input logic [15:0] a, input logic [15:0] b);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'({16'd0, a}) * longint'({16'd0, b});
    return p[31:0];
  endfunction

  // Edges from the St-sampling edge to the Done cycle.
  function automatic int ref_latency(input bit ee, input bit s, input logic [15:0] b);
    logic [15:0] mag;
    int steps;
    if (!ee) return 17;
    mag   = (s && b[15]) ? 16'(-b) : b;
    steps = 1;
    for (int i = 0; i < 16; i++) if (mag[i]) steps = i + 1;
    return steps + 1;
  endfunction

  // Model state per instance.
  bit          m_valid [2];
  bit          m_busy  [2];
  bit          m_done  [2];
  int          m_rem   [2];
  logic [31:0] m_prod  [2];
  logic [31:0] m_pend  [2];

  // Compare outputs for the current cycle, then predict the next edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_valid[k]) begin
        check($sformatf("dut%0d Done", k),    done_o[k], m_done[k]);
        check($sformatf("dut%0d Idle", k),    idle_o[k], !m_busy[k]);
        check($sformatf("dut%0d Produto", k), prod_o[k], m_prod[k]);
      end
      m_done[k] = 1'b0;
      if (rst) begin
        m_valid[k] = 1'b1;
        m_busy[k]  = 1'b0;
        m_rem[k]   = 0;
        m_prod[k]  = '0;
      end else if (!m_busy[k]) begin
        if (st_i[k]) begin
          m_busy[k] = 1'b1;
          m_rem[k]  = ref_latency(k == 1, sgn_i[k], b_i[k]);
          m_pend[k] = ref_product(sgn_i[k], a_i[k], b_i[k]);
        end
      end else begin
        m_rem[k]--;
        if (m_rem[k] == 0) begin
          m_busy[k] = 1'b0;
          m_done[k] = 1'b1;
          m_prod[k] = m_pend[k];
        end
      end
    end
  end

  // Count edges until Done is seen; bounded.
  task automatic wait_done(input int k, output int n);
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (done_o[k] === 1'b1) break;
      if (n >= 60) begin
        check($sformatf("dut%0d Done timeout", k), 64'd0, 64'd1);
        break;
      end
    end
  endtask

  // One operation from IDLE; operands are scrambled while busy.
  task automatic run_op(input int k, input bit s, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] ep, input int el, input string name);
    int n;
    sgn_i[k] = s; a_i[k] = a; b_i[k] = b; st_i[k] = 1'b1;
    @(posedge clk); #1;
    st_i[k]  = 1'b0;
    a_i[k]   = 16'($urandom);
    b_i[k]   = 16'($urandom);
    sgn_i[k] = 1'($urandom);
    wait_done(k, n);
    check({name, " product"}, prod_o[k], ep);
    check({name, " latency"}, n, el);
    check({name, " idle"}, idle_o[k], 1'b1);
  endtask

  initial begin
    int n, n2;
    bit s;
    logic [15:0] a, b;
    a_i[0] = '0; a_i[1] = '0; b_i[0] = '0; b_i[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset Done",    done_o[0], 1'b0);
    check("reset Idle",    idle_o[0], 1'b1);
    check("reset Produto", prod_o[0], 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fixed latency, directed.
    run_op(0, 0, 16'd3,    16'd5,    32'd15,         17, "u 3x5");
    run_op(0, 0, 16'd7,    16'd7,    32'd49,         17, "u 7x7");
    run_op(0, 0, 16'd12,   16'd3,    32'd36,         17, "u 12x3");
    run_op(0, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001,   17, "u max x max");
    run_op(0, 1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1,   17, "s -3x5");
    run_op(0, 1, 16'h8000, 16'h8000, 32'h40000000,   17, "s minneg^2");
    run_op(0, 1, 16'h8000, 16'h0001, 32'hFFFF8000,   17, "s minneg x 1");
    run_op(0, 1, 16'h0000, 16'hFFFF, 32'h00000000,   17, "s 0 x -1");

    // Early exit, directed.
    run_op(1, 0, 16'd1000, 16'd0,    32'd0,          2,  "ee 1000x0");
    run_op(1, 0, 16'd1000, 16'd3,    32'd3000,       3,  "ee 1000x3");
    run_op(1, 0, 16'd1,    16'h8000, 32'h00008000,   17, "ee 1x8000");
    run_op(1, 1, 16'hFFFF, 16'hFFFF, 32'd1,          2,  "ee s -1x-1");

    // St and operands changed during CALC are ignored.
    sgn_i[0] = 0; a_i[0] = 16'd3; b_i[0] = 16'd5; st_i[0] = 1'b1;
    @(posedge clk); #1;
    st_i[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    st_i[0] = 1'b1; a_i[0] = 16'd9; b_i[0] = 16'd9;
    repeat (3) @(posedge clk);
    #1;
    st_i[0] = 1'b0;
    wait_done(0, n);
    check("restart ignored product", prod_o[0], 32'd15);
    check("restart ignored latency", n + 7, 17);

    // St held high: back-to-back operations.
    a_i[0] = 16'd7; b_i[0] = 16'd7; st_i[0] = 1'b1;
    wait_done(0, n);
    wait_done(0, n2);
    st_i[0] = 1'b0;
    check("held St gap",     n2, 18);
    check("held St product", prod_o[0], 32'd49);
    repeat (20) @(posedge clk);
    #1;

    // Reset in the middle of CALC; St on the reset edge is ignored.
    a_i[0] = 16'd5; b_i[0] = 16'd6; st_i[0] = 1'b1;
    @(posedge clk); #1;
    st_i[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1; st_i[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; st_i[0] = 1'b0;
    check("mid rst Idle",    idle_o[0], 1'b1);
    check("mid rst Done",    done_o[0], 1'b0);
    check("mid rst Produto", prod_o[0], 32'd0);
    run_op(0, 0, 16'd4, 16'd4, 32'd16, 17, "post rst 4x4");

    // Random operations on both instances.
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      if (i % 7 == 0) a = 16'h8000;
      run_op(i % 2, s, a, b, ref_product(s, a, b), ref_latency((i % 2) == 1, s, b),
             $sformatf("rand%0d", i));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
